divisor_sequencial: RTL and testbench
=====================================

# divisor_sequencial

Sequential shift-subtract (restoring) unsigned divider: a 2N-bit dividend divided by an N-bit divisor gives an N-bit quotient and an N-bit remainder. It is the inverse datapath of the shift-add multiplier in the MIPS_CPU arithmetic group. It uses the same St/Idle/Done handshake, so the CPU control can drive either unit the same way. It resolves one quotient bit per clock and flags overflow and divide-by-zero up front instead of producing garbage.

## Interface
- N, default 4: divisor, quotient and remainder width. The dividend is 2N bits.
- Clk  input  1  the single clock. All state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset. It asserts immediately and releases synchronously to Clk.
- St  input  1  start request. Sampled only in IDLE.
- Dividendo  input  2N  dividend. Sampled on the edge that accepts St.
- Divisor  input  N  divisor. Sampled on the edge that accepts St.
- Quociente  output  N  quotient, registered.
- Resto  output  N  remainder, registered.
- V  output  1  overflow flag, registered.
- Idle  output  1  high when state is IDLE.
- Done  output  1  one-cycle pulse; results are valid while it is high.
- DZ  output  1  divide-by-zero flag. Present only with DIVISOR_ZERO_FLAG_EN.

## Operation
- Internal registers: ACC (2N bits), a divisor latch D (N bits), an iteration counter (ceil(log2 N)+1 bits) and a 2-bit state.
- IDLE:
  - Idle=1.
  - On St=1: ACC<=Dividendo, D<=Divisor, clear V/Quociente/Resto (and DZ), go to CHECK.
- CHECK:
  - If ACC[2N-1:N] >= D, the quotient cannot fit in N bits. This includes D==0.
  - On overflow: V<=1, Quociente<=0, Resto<=0, go to DONE.
  - Otherwise: counter<=0, go to DIV.
- DIV, one quotient bit per cycle:
  - Compute T = {1'b0... ACC[2N-1:N-1]} (N+1 bits) minus {1'b0, D}.
  - If T >= 0: ACC <= {T[N-1:0], ACC[N-2:0], 1'b1}.
  - Otherwise: ACC <= {ACC[2N-2:0], 1'b0}.
  - The counter increments each iteration. After iteration N (counter==N-1) go to DONE.
  - On that same edge, Quociente and Resto load the final ACC values: Quociente = ACC[N-1:0], Resto = ACC[2N-1:N].
- DONE:
  - Done=1 for exactly one cycle, then unconditionally return to IDLE.
  - St is ignored here.
- Invariant: ACC[2N-1:N] < D holds throughout DIV, so T never needs more than N result bits.
- Result hold: Quociente, Resto, V (and DZ) hold their values after DONE until the next St is accepted.
- St is ignored in CHECK, DIV and DONE. A request is never queued.
- Input changes: Dividendo and Divisor may change freely after acceptance; only the latched copies are used.

## Timing
- St=1 sampled at edge k (state IDLE) → Idle falls after edge k.
- Normal division: Done high in the cycle after edge k+N+1, i.e. N+2 cycles after acceptance (6 for N=4). Results are valid in that same cycle.
- Overflow or divide-by-zero: Done high in the cycle after edge k+1, i.e. 2 cycles after acceptance.
- Idle returns high one cycle after Done. The earliest next acceptance is that edge, so N+3 edges per normal operation.
- St held permanently high: back-to-back operations, each starting on the first edge with Idle=1.
- Reset values (reset low): state=IDLE, Idle=1, Done=0, V=0, DZ=0, Quociente=0, Resto=0, ACC=0, counter=0.
- Reset mid-operation (any state): abort immediately. No Done pulse is produced for the aborted operation.

## Configuration
- DIVISOR_ZERO_FLAG_EN defined:
  - The DZ port exists.
  - In CHECK, if D==0, DZ<=1 together with V<=1.
  - DZ is cleared on the next accepted St.
- DIVISOR_ZERO_FLAG_EN undefined:
  - No DZ port.
  - Divide-by-zero is reported only as V=1, because the overflow compare covers it. Behaviour and timing are otherwise identical.

## Test plan
- Nominal: N=4, Dividendo=8'h87, Divisor=4'hD → 6 cycles after St, Done=1, Quociente=4'hA, Resto=4'h5, V=0.
- Largest legal quotient: 8'hEF / 4'hF → Quociente=4'hF, Resto=4'hE, V=0, normal latency.
- Overflow: 8'hF0 / 4'h3 → Done 2 cycles after St, V=1, Quociente=0, Resto=0. DZ=0 when enabled.
- Divide-by-zero: 8'h05 / 4'h0 → Done after 2 cycles, V=1. DZ=1 with DIVISOR_ZERO_FLAG_EN.
- Handshake:
  - Pulse St during DIV with different operands → ignored; the first result is unchanged.
  - St held high → two back-to-back results, 7 edges apart.
  - Results hold stable between operations.
- Reset: assert reset low during the third DIV cycle → Idle=1 and all outputs 0 immediately, no Done pulse. A new St after release runs normally.

Source files
------------

// File: rtl/divisor_sequencial.sv
// divisor_sequencial: restoring shift-subtract unsigned divider.
// 2N-bit dividend / N-bit divisor -> N-bit quotient and N-bit remainder.
// The divider resolves one quotient bit per clock.
// Overflow, including divide-by-zero, is detected before iterating.
// Optional feature macro: DIVISOR_ZERO_FLAG_EN adds the DZ divide-by-zero flag port.
module divisor_sequencial #(
  parameter int unsigned N = 4
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             St,
  input  logic [2*N-1:0]   Dividendo,
  input  logic [N-1:0]     Divisor,
  output logic [N-1:0]     Quociente,
  output logic [N-1:0]     Resto,
  output logic             V,
  output logic             Idle,
  output logic             Done
`ifdef DIVISOR_ZERO_FLAG_EN
  ,
  output logic             DZ
`endif
);

  localparam int unsigned AW = 2 * N;
  localparam int unsigned CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_DIV   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [N-1:0]    div_q, div_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    quo_q, quo_d;
  logic [N-1:0]    rem_q, rem_d;
  logic            v_q, v_d;
  logic            idle_q, idle_d;
  logic            done_q, done_d;
`ifdef DIVISOR_ZERO_FLAG_EN
  logic            dz_q, dz_d;
`endif

  // Trial subtraction of the divisor from the shifted partial remainder.
  logic [N:0]      part_rem;
  logic            trial_ge;
  logic [N-1:0]    trial_lo;

  assign part_rem = acc_q[AW-1:N-1];
  assign trial_ge = (part_rem >= (N+1)'(div_q));
  assign trial_lo = N'(part_rem - (N+1)'(div_q));

  // Next-state and datapath update for the divider FSM.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    v_d     = v_q;
`ifdef DIVISOR_ZERO_FLAG_EN
    dz_d    = dz_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (St) begin
          acc_d   = Dividendo;
          div_d   = Divisor;
          quo_d   = '0;
          rem_d   = '0;
          v_d     = 1'b0;
`ifdef DIVISOR_ZERO_FLAG_EN
          dz_d    = 1'b0;
`endif
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        // A high half not below the divisor means the quotient needs more than N bits.
        if (acc_q[AW-1:N] >= div_q) begin
          v_d     = 1'b1;
          quo_d   = '0;
          rem_d   = '0;
`ifdef DIVISOR_ZERO_FLAG_EN
          dz_d    = (div_q == '0);
`endif
          state_d = S_DONE;
        end else begin
          cnt_d   = '0;
          state_d = S_DIV;
        end
      end

      S_DIV: begin
        if (trial_ge) begin
          acc_d = {trial_lo, acc_q[N-2:0], 1'b1};
        end else begin
          acc_d = {acc_q[AW-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          quo_d   = acc_d[N-1:0];
          rem_d   = acc_d[AW-1:N];
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    idle_d = (state_d == S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      v_q     <= 1'b0;
      idle_q  <= 1'b1;
      done_q  <= 1'b0;
`ifdef DIVISOR_ZERO_FLAG_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      v_q     <= v_d;
      idle_q  <= idle_d;
      done_q  <= done_d;
`ifdef DIVISOR_ZERO_FLAG_EN
      dz_q    <= dz_d;
`endif
    end
  end

  assign Quociente = quo_q;
  assign Resto     = rem_q;
  assign V         = v_q;
  assign Idle      = idle_q;
  assign Done      = done_q;
`ifdef DIVISOR_ZERO_FLAG_EN
  assign DZ        = dz_q;
`endif

endmodule

// File: tb/tb_divisor_sequencial.sv
// Bench for divisor_sequencial (N=4).
// Stimulus pushes hand-computed expected results into a scoreboard queue.
// A forked monitor pops and compares the queue on every Done pulse.
module tb_divisor_sequencial;

  localparam int unsigned N = 4;

  logic           Clk;
  logic           reset;
  logic           St;
  logic [2*N-1:0] Dividendo;
  logic [N-1:0]   Divisor;
  logic [N-1:0]   Quociente;
  logic [N-1:0]   Resto;
  logic           V;
  logic           Idle;
  logic           Done;
`ifdef DIVISOR_ZERO_FLAG_EN
  logic           DZ;
`endif

  divisor_sequencial #(.N(N)) dut (
    .Clk       (Clk),
    .reset     (reset),
    .St        (St),
    .Dividendo (Dividendo),
    .Divisor   (Divisor),
    .Quociente (Quociente),
    .Resto     (Resto),
    .V         (V),
    .Idle      (Idle),
    .Done      (Done)
`ifdef DIVISOR_ZERO_FLAG_EN
    ,
    .DZ        (DZ)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         v;
    logic         dz;
    int           lat;
  } exp_t;

  exp_t sbq[$];
  int   done_cyc[$];
  int   n_cmp;
  int   n_err;
  int   cyc;
  int   accept_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(posedge Clk);
      cyc++;
      if (reset && St && Idle) accept_cyc = cyc;
      @(negedge Clk);
      if (Done) begin
        done_cyc.push_back(cyc);
        if (sbq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: Done=1 with no pending vector at cycle %0d", cyc);
        end else begin
          e = sbq.pop_front();
          chk("quotient", 32'(Quociente), 32'(e.q));
          chk("remainder", 32'(Resto), 32'(e.r));
          chk("overflow", 32'(V), 32'(e.v));
`ifdef DIVISOR_ZERO_FLAG_EN
          chk("div_zero", 32'(DZ), 32'(e.dz));
`endif
          chk("latency", 32'(cyc - accept_cyc), 32'(e.lat));
        end
      end
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (Idle) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: Idle still %0b after 40 cycles, expected 1", Idle);
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (sbq.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge Clk);
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: %0d results outstanding, expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  // Called at a negedge with the DUT idle: the next rising edge accepts the request.
  task automatic issue(input logic [2*N-1:0] dd, input logic [N-1:0] dv, input bit push,
                       input logic [N-1:0] q, input logic [N-1:0] r, input logic v,
                       input logic dz, input int lat);
    exp_t e;
    if (push) begin
      e.q = q; e.r = r; e.v = v; e.dz = dz; e.lat = lat;
      sbq.push_back(e);
    end
    St        = 1'b1;
    Dividendo = dd;
    Divisor   = dv;
    @(posedge Clk);
    #1;
    chk("idle_fall", 32'(Idle), 32'(0));
    @(negedge Clk);
    St        = 1'b0;
    Dividendo = (2*N)'($urandom);
    Divisor   = N'($urandom);
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    cyc        = 0;
    accept_cyc = 0;
    reset      = 1'b0;
    St         = 1'b0;
    Dividendo  = '0;
    Divisor    = '0;
    fork
      monitor();
    join_none

    // Reset state
    #12;
    chk("rst_idle", 32'(Idle), 32'(1));
    chk("rst_done", 32'(Done), 32'(0));
    chk("rst_quotient", 32'(Quociente), 32'(0));
    chk("rst_remainder", 32'(Resto), 32'(0));
    chk("rst_overflow", 32'(V), 32'(0));
`ifdef DIVISOR_ZERO_FLAG_EN
    chk("rst_div_zero", 32'(DZ), 32'(0));
`endif
    @(negedge Clk);
    reset = 1'b1;
    wait_idle();

    // Directed vectors: dividend, divisor -> quotient, remainder, V, DZ, edges to Done
    issue(8'h87, 4'hD, 1'b1, 4'hA, 4'h5, 1'b0, 1'b0, 5); drain(); wait_idle();
    issue(8'hEF, 4'hF, 1'b1, 4'hF, 4'hE, 1'b0, 1'b0, 5); drain(); wait_idle();
    issue(8'hF0, 4'h3, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0, 1); drain(); wait_idle();
    issue(8'h05, 4'h0, 1'b1, 4'h0, 4'h0, 1'b1, 1'b1, 1); drain(); wait_idle();
    issue(8'h64, 4'h7, 1'b1, 4'hE, 4'h2, 1'b0, 1'b0, 5); drain(); wait_idle();
    issue(8'h00, 4'h1, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 5); drain(); wait_idle();
    issue(8'h40, 4'h4, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0, 1); drain(); wait_idle();
    issue(8'h3F, 4'h4, 1'b1, 4'hF, 4'h3, 1'b0, 1'b0, 5); drain(); wait_idle();

    // Results hold while idle
    repeat (5) @(negedge Clk);
    chk("hold_quotient", 32'(Quociente), 32'(4'hF));
    chk("hold_remainder", 32'(Resto), 32'(4'h3));
    chk("hold_overflow", 32'(V), 32'(0));

    // St pulsed during DIV with other operands is ignored
    issue(8'h87, 4'hD, 1'b1, 4'hA, 4'h5, 1'b0, 1'b0, 5);
    @(negedge Clk);
    St = 1'b1; Dividendo = 8'h12; Divisor = 4'h1;
    @(negedge Clk);
    St = 1'b0;
    drain();
    repeat (10) @(negedge Clk);
    chk("ignored_st_quotient", 32'(Quociente), 32'(4'hA));
    chk("ignored_st_idle", 32'(Idle), 32'(1));

    // St held high: two back-to-back operations 7 edges apart
    begin
      exp_t e;
      e.q = 4'h8; e.r = 4'h2; e.v = 1'b0; e.dz = 1'b0; e.lat = 5;
      sbq.push_back(e);
      sbq.push_back(e);
    end
    St = 1'b1; Dividendo = 8'h2A; Divisor = 4'h5;
    repeat (8) @(posedge Clk);
    @(negedge Clk);
    St = 1'b0;
    drain();
    wait_idle();
    if (done_cyc.size() >= 2)
      chk("b2b_spacing", 32'(done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2]), 32'(7));
    else
      chk("b2b_done_count", 32'(done_cyc.size()), 32'(2));

    // Reset during the third DIV cycle aborts with no Done
    issue(8'h87, 4'hD, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 0);
    repeat (3) @(posedge Clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_idle", 32'(Idle), 32'(1));
    chk("abort_done", 32'(Done), 32'(0));
    chk("abort_quotient", 32'(Quociente), 32'(0));
    chk("abort_remainder", 32'(Resto), 32'(0));
    chk("abort_overflow", 32'(V), 32'(0));
    @(negedge Clk);
    reset = 1'b1;
    repeat (10) @(negedge Clk);
    issue(8'h64, 4'h7, 1'b1, 4'hE, 4'h2, 1'b0, 1'b0, 5); drain(); wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
